if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction queue.
- Holds the fetch PC and requests one 32-bit instruction at a time from the instruction cache.
- Predicts the next PC with a direct-mapped BTB and 2-bit counters, then pushes {inst, PC, predicted next PC, predict bit} into the queue when it is not full.
- Redirects on roll and trains the BTB from branch-resolution updates.

Parameters:
- BTB_IDX_W, 6: BTB index width; 2^BTB_IDX_W entries, indexed by PC[BTB_IDX_W+1:2], tag is PC[31:BTB_IDX_W+2].
- RESET_PC, 32'h0: PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- roll  in  1  misprediction flush
- roll_pc  in  32  correct PC after flush
- IC_req  out  1  fetch request, level, held until IC_done
- IC_addr  out  32  fetch address, stable while IC_req high
- IC_done  in  1  one-cycle pulse, response valid
- IC_inst  in  32  instruction, valid with IC_done
- IQ_full  in  1  queue full (registered by queue)
- IF_flag  out  1  push pulse to queue
- IF_inst  out  32  instruction pushed
- IF_PC  out  32  its PC
- IF_BTB_PC  out  32  predicted next PC
- IF_BTB_predict  out  1  predicted taken
- upd_flag  in  1  branch resolved
- upd_pc  in  32  resolved branch PC
- upd_target  in  32  resolved taken target
- upd_taken  in  1  actual direction

Behaviour:
- Reset values:
  - pc = RESET_PC; state = FETCH.
  - IC_req = 0; IC_addr = 0.
  - IF_flag = 0; IF_inst = 0; IF_PC = 0; IF_BTB_PC = 0; IF_BTB_predict = 0.
  - All BTB valid bits = 0; counters = 2'b01.
- Priority: rst > roll > !rdy (hold everything, including IF_flag and the IC_req level) > normal operation.
- States:
  - FETCH: drive IC_req = 1, IC_addr = pc; go to WAIT.
  - WAIT: on IC_done, capture the instruction into a holding register. If !IQ_full, push it the same edge (IF_flag = 1 next cycle) and go to FETCH with pc = next_pc. If IQ_full, go to HOLD.
  - HOLD: IC_req = 0; when !IQ_full, push, set pc = next_pc, go to FETCH.
  - DISCARD: keep IC_req high until IC_done, drop the returned instruction, IC_req = 0, then FETCH at the saved redirect PC.
- IF_flag is a registered one-cycle pulse. It is never asserted in a cycle where IQ_full was high at the preceding edge. Maximum throughput is one instruction per 2 cycles plus cache latency.
- Prediction (combinational on pc):
  - hit = valid && tag match.
  - predict = hit && ctr[1].
  - next_pc = predict ? target : pc+4, using 32-bit wrap-around add.
  - IF_BTB_PC = next_pc; IF_BTB_predict = predict, both sampled for the pushed instruction.
- Roll:
  - IF_flag = 0 next cycle; pending holding register is discarded.
  - If IC_req is outstanding (WAIT), enter DISCARD with redirect = roll_pc.
  - Otherwise, pc = roll_pc and go to FETCH.
  - A roll that coincides with IC_done in WAIT drops that instruction and goes straight to FETCH at roll_pc.
  - A roll during DISCARD overwrites the redirect PC.
- BTB update, on upd_flag && rdy (applied even in a roll cycle):
  - Hit: counter saturating +1 if taken, -1 if not; if taken, target = upd_target.
  - Miss and taken: allocate entry with tag, target, ctr = 2'b10.
  - Miss and not taken: no change.
  - An update and a lookup on the same index in one cycle: lookup sees the old entry.

Optional Feature:
- IF_BTB_EN
- Defined: BTB instantiated as above.
- Undefined: no BTB storage; predict = 0 and next_pc = pc+4 always; upd_* ignored; IF_BTB_predict tied 0.

Decomposition:
- Shared define.v additions: `BTB_IDX_W default, counter encodings (STRONG_NT = 0 .. STRONG_T = 3), fetch state encodings, reuse of `TRUE / `FALSE.
- One sub-module, if_btb: storage, lookup port, update port.

Test Plan:
- Reset, cache 2-cycle latency, IQ never full, insts 0x00000013 ... -> pushes at PC 0, 4, 8 with IF_BTB_PC = PC+4 and predict = 0.
- IQ_full held high 5 cycles after IC_done -> no IF_flag during hold; single push on the first cycle after IQ_full drops; no duplicate push.
- Roll in WAIT with roll_pc = 0x100, late IC_done = 0xDEADBEEF -> that instruction is never pushed; next IC_addr = 0x100.
- upd_pc = 0x10 taken to 0x40, then fetch 0x10 -> IF_BTB_predict = 1, IF_BTB_PC = 0x40, next IC_addr = 0x40; two not-taken updates -> predict = 0.
- rdy low for 3 cycles mid-WAIT -> all outputs frozen; resumes identically.
- pc = 0xFFFFFFFC with BTB miss -> IF_BTB_PC = 0x00000000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: BTB defaults,
// 2-bit counter encodings, fetch FSM states and the counter update helper.
package if_fetch_pkg;

    localparam int   BTB_IDX_W_DEFAULT = 6;
    localparam logic TRUE              = 1'b1;
    localparam logic FALSE             = 1'b0;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } btb_ctr_e;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    function automatic btb_ctr_e ctr_step(btb_ctr_e ctr, logic taken);
        if (taken)
            return (ctr == STRONG_T) ? STRONG_T : btb_ctr_e'(ctr + 2'd1);
        return (ctr == STRONG_NT) ? STRONG_NT : btb_ctr_e'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's cache, queue, redirect and BTB-training signals.
// master = fetch stage, slave = surrounding pipeline (cache, queue, resolver).
interface if_fetch_if;

    // IC_req is a level held until the one-cycle IC_done pulse; IF_flag is a
    // one-cycle push that is only raised when IQ_full was low at that edge.
    logic        rdy;
    logic        roll;
    logic [31:0] roll_pc;
    logic        IC_req;
    logic [31:0] IC_addr;
    logic        IC_done;
    logic [31:0] IC_inst;
    logic        IQ_full;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC;
    logic [31:0] IF_BTB_PC;
    logic        IF_BTB_predict;
    logic        upd_flag;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;

    modport master (
        input  rdy, roll, roll_pc, IC_done, IC_inst, IQ_full,
               upd_flag, upd_pc, upd_target, upd_taken,
        output IC_req, IC_addr, IF_flag, IF_inst, IF_PC, IF_BTB_PC, IF_BTB_predict
    );

    modport slave (
        output rdy, roll, roll_pc, IC_done, IC_inst, IQ_full,
               upd_flag, upd_pc, upd_target, upd_taken,
        input  IC_req, IC_addr, IF_flag, IF_inst, IF_PC, IF_BTB_PC, IF_BTB_predict
    );

endinterface

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; only built when
// IF_BTB_EN is defined. Lookup is combinational, training is registered.
`ifdef IF_BTB_EN
module if_btb
    import if_fetch_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] lookup_pc,
    output logic        predict,
    output logic [31:0] target,
    input  logic        upd_en,
    input  logic [31:2] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic              valid   [ENTRIES];
    logic [TAG_W-1:0]  tags    [ENTRIES];
    logic [31:0]       targets [ENTRIES];
    btb_ctr_e          ctrs    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, up_hit;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[31:IDX_W+2];
    assign up_idx  = upd_pc[IDX_W+1:2];
    assign up_tag  = upd_pc[31:IDX_W+2];
    assign lk_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign up_hit  = valid[up_idx] && (tags[up_idx] == up_tag);
    assign predict = lk_hit && ctrs[lk_idx][1];
    assign target  = targets[lk_idx];

    // Tags and targets are qualified by valid, so only valid/ctr need reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= FALSE;
                ctrs[i]  <= WEAK_NT;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                ctrs[up_idx] <= ctr_step(ctrs[up_idx], upd_taken);
                if (upd_taken)
                    targets[up_idx] <= upd_target;
            end else if (upd_taken) begin
                valid[up_idx]   <= TRUE;
                tags[up_idx]    <= up_tag;
                targets[up_idx] <= upd_target;
                ctrs[up_idx]    <= WEAK_T;
            end
        end
    end

endmodule
`endif

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding cache request, BTB next-PC
// prediction when IF_BTB_EN is defined (pc+4 otherwise), push into the queue.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          BTB_IDX_W = BTB_IDX_W_DEFAULT,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    if_fetch_if.master   bus,
    output fetch_state_e state
);

    logic [31:0] pc;
    logic [31:0] redirect_pc;
    logic [31:0] hold_inst;
    logic [31:0] next_pc;
    logic [31:0] push_inst;
    logic        predict;
    logic        push_now;

`ifdef IF_BTB_EN
    logic [31:0] btb_target;

    if_btb #(.IDX_W(BTB_IDX_W)) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc[31:2]),
        .predict    (predict),
        .target     (btb_target),
        .upd_en     (bus.upd_flag && bus.rdy),
        .upd_pc     (bus.upd_pc[31:2]),
        .upd_target (bus.upd_target),
        .upd_taken  (bus.upd_taken)
    );

    assign next_pc = predict ? btb_target : pc + 32'd4;
`else
    assign predict = FALSE;
    assign next_pc = pc + 32'd4;
`endif

    // A push happens straight from the cache response or later from HOLD.
    assign push_now  = !bus.IQ_full &&
                       ((state == WAIT && bus.IC_done) || state == HOLD);
    assign push_inst = (state == HOLD) ? hold_inst : bus.IC_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= FETCH;
            pc                 <= RESET_PC;
            redirect_pc        <= 32'h0;
            hold_inst          <= 32'h0;
            bus.IC_req         <= FALSE;
            bus.IC_addr        <= 32'h0;
            bus.IF_flag        <= FALSE;
            bus.IF_inst        <= 32'h0;
            bus.IF_PC          <= 32'h0;
            bus.IF_BTB_PC      <= 32'h0;
            bus.IF_BTB_predict <= FALSE;
        end else if (bus.roll) begin
            bus.IF_flag <= FALSE;
            // An outstanding request must still drain before refetching.
            if (bus.IC_req && !bus.IC_done) begin
                state       <= DISCARD;
                redirect_pc <= bus.roll_pc;
            end else begin
                state      <= FETCH;
                pc         <= bus.roll_pc;
                bus.IC_req <= FALSE;
            end
        end else if (bus.rdy) begin
            bus.IF_flag <= FALSE;
            if (push_now) begin
                bus.IF_flag        <= TRUE;
                bus.IF_inst        <= push_inst;
                bus.IF_PC          <= pc;
                bus.IF_BTB_PC      <= next_pc;
                bus.IF_BTB_predict <= predict;
                pc                 <= next_pc;
            end
            unique case (state)
                FETCH: begin
                    bus.IC_req  <= TRUE;
                    bus.IC_addr <= pc;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.IC_done) begin
                        bus.IC_req <= FALSE;
                        hold_inst  <= bus.IC_inst;
                        state      <= bus.IQ_full ? HOLD : FETCH;
                    end
                end
                HOLD: begin
                    if (!bus.IQ_full)
                        state <= FETCH;
                end
                DISCARD: begin
                    if (bus.IC_done) begin
                        bus.IC_req <= FALSE;
                        pc         <= redirect_pc;
                        state      <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule
